// File: rtl/switch_debouncer_if.sv
// Signal bundle between the slide-switch debouncer and its processor-side peer.
// The debouncer uses the slave view; the switch pins and processor use the master view.
interface switch_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] SWITCHES_RAW;
  logic [WIDTH-1:0] SWITCHES_CLEAN;
  logic [WIDTH-1:0] CHANGE_MASK;
  logic             INTERRUPT_RAISE;
  logic             INTERRUPT_ACK;

  modport slave (
    input  SWITCHES_RAW,
    input  INTERRUPT_ACK,
    output SWITCHES_CLEAN,
    output CHANGE_MASK,
    output INTERRUPT_RAISE
  );

  modport master (
    output SWITCHES_RAW,
    output INTERRUPT_ACK,
    input  SWITCHES_CLEAN,
    input  CHANGE_MASK,
    input  INTERRUPT_RAISE
  );
endinterface

// File: rtl/switch_debouncer.sv
// Synchronises and debounces slide-switch pins bit by bit, records which bits
// changed and raises a level interrupt until the processor acknowledges it.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic               CLK,
  input  logic               RESET,
  switch_debouncer_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync1_q, sync1_d;
  logic [WIDTH-1:0]     sync2_q, sync2_d;
  logic [WIDTH-1:0]     clean_q, clean_d;
  logic [WIDTH-1:0]     mask_q,  mask_d;
  logic                 irq_q,   irq_d;
  logic [WIDTH-1:0]     update;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sync1_d = bus.SWITCHES_RAW;
    sync2_d = sync1_q;
    clean_d = clean_q;
    update  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Accept the new level; the counter restarts for the next transition.
        clean_d[i] = sync2_q[i];
        update[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end

    // A fresh update wins over an acknowledge landing in the same cycle.
    mask_d = (bus.INTERRUPT_ACK ? '0 : mask_q) | update;
    irq_d  = bus.INTERRUPT_ACK ? 1'b0 : (|mask_q);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
      // NOTE: the counter array is reset too; a stale count would let a bit be
      // accepted early after a reset that lands mid-debounce.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.SWITCHES_CLEAN  = clean_q;
  assign bus.CHANGE_MASK     = mask_q;
  assign bus.INTERRUPT_RAISE = irq_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus random stimulus,
// every cycle compared against a window-based reference model of the debounce rules.
module tb_switch_debouncer;

  localparam int W      = 8;
  localparam int D      = 4;
  localparam int MAX_E  = 4096;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = '0;
  logic         ack = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) bus ();

  assign bus.SWITCHES_RAW  = raw;
  assign bus.INTERRUPT_ACK = ack;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(20)
  ) u_dut (
    .CLK(clk),
    .RESET(rst_n),
    .bus(bus)
  );

  // Reference model: raw history per edge, the value the debouncer sees at each
  // edge (raw delayed two edges, zero shortly after reset), and the edge of each
  // bit's last reset/acceptance. A bit is accepted when it has seen the same
  // differing value on D consecutive edges since its last event.
  logic [W-1:0] raw_h  [MAX_E];
  logic [W-1:0] seen_h [MAX_E];
  int           last_evt [W];
  int           last_rst = 0;
  int           edge_n = 0;
  logic [W-1:0] m_clean = '0;
  logic [W-1:0] m_mask  = '0;
  logic         m_irq   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge(input int n, input logic r_n, input logic a);
    logic [W-1:0] upd;
    logic [W-1:0] nxt;
    if (!r_n) begin
      last_rst  = n;
      seen_h[n] = '0;
      m_clean   = '0;
      m_mask    = '0;
      m_irq     = 1'b0;
      for (int i = 0; i < W; i++) last_evt[i] = n;
    end else begin
      seen_h[n] = (n - 2 > last_rst) ? raw_h[n-2] : '0;
      upd = '0;
      nxt = m_clean;
      for (int i = 0; i < W; i++) begin
        logic v;
        bit   ok;
        v  = seen_h[n][i];
        ok = (v != m_clean[i]);
        for (int k = 0; k < D; k++) begin
          if (n - k <= last_evt[i]) ok = 0;
          else if (seen_h[n-k][i] != v) ok = 0;
        end
        if (ok) begin
          upd[i]      = 1'b1;
          nxt[i]      = v;
          last_evt[i] = n;
        end
      end
      m_irq   = a ? 1'b0 : (m_mask != '0);
      m_mask  = (a ? '0 : m_mask) | upd;
      m_clean = nxt;
    end
  endtask

  // One clock edge with the current inputs, then a full model comparison.
  task automatic step();
    logic r_n;
    logic a;
    edge_n++;
    raw_h[edge_n] = raw;
    r_n = rst_n;
    a   = ack;
    @(posedge clk);
    #1;
    model_edge(edge_n, r_n, a);
    check("clean", bus.SWITCHES_CLEAN, m_clean);
    check("mask", bus.CHANGE_MASK, m_mask);
    check("irq", bus.INTERRUPT_RAISE, m_irq);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    // Reset with all switches on.
    raw   = 8'hFF;
    rst_n = 1'b0;
    steps(2);
    check("rst_clean", bus.SWITCHES_CLEAN, 8'h00);
    check("rst_mask", bus.CHANGE_MASK, 8'h00);
    check("rst_irq", bus.INTERRUPT_RAISE, 1'b0);
    rst_n = 1'b1;
    steps(5);
    check("rst_clean_early", bus.SWITCHES_CLEAN, 8'h00);
    step();
    check("rst_clean_6", bus.SWITCHES_CLEAN, 8'hFF);
    check("rst_mask_6", bus.CHANGE_MASK, 8'hFF);
    check("rst_irq_6", bus.INTERRUPT_RAISE, 1'b0);
    step();
    check("rst_irq_7", bus.INTERRUPT_RAISE, 1'b1);
    ack_pulse();

    // Settle back to all-off.
    raw = 8'h00;
    steps(8);
    check("settle_clean", bus.SWITCHES_CLEAN, 8'h00);
    ack_pulse();
    steps(2);

    // Clean step 00 -> 05.
    raw = 8'h05;
    steps(5);
    check("step_not_before", bus.SWITCHES_CLEAN, 8'h00);
    step();
    check("step_clean", bus.SWITCHES_CLEAN, 8'h05);
    check("step_mask", bus.CHANGE_MASK, 8'h05);
    step();
    check("step_irq", bus.INTERRUPT_RAISE, 1'b1);

    // Acknowledge.
    ack_pulse();
    check("ack_mask", bus.CHANGE_MASK, 8'h00);
    check("ack_irq", bus.INTERRUPT_RAISE, 1'b0);
    check("ack_clean", bus.SWITCHES_CLEAN, 8'h05);
    steps(2);

    // Bounce rejection on bit 3.
    for (int c = 0; c < 20; c++) begin
      raw[3] = ((c / 2) % 2) == 0;
      step();
      check("bounce_hold", bus.SWITCHES_CLEAN[3], 1'b0);
    end
    raw[3] = 1'b1;
    steps(5);
    check("bounce_not_before", bus.SWITCHES_CLEAN[3], 1'b0);
    step();
    check("bounce_accept", bus.SWITCHES_CLEAN[3], 1'b1);
    check("bounce_mask", bus.CHANGE_MASK, 8'h08);
    ack_pulse();
    steps(2);

    // ACK colliding with bit 7's update while mask = 01.
    raw = 8'h0C;
    steps(6);
    check("coll_mask_pre", bus.CHANGE_MASK, 8'h01);
    raw = 8'h8C;
    steps(5);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("coll_mask", bus.CHANGE_MASK, 8'h80);
    check("coll_irq_low", bus.INTERRUPT_RAISE, 1'b0);
    step();
    check("coll_irq_high", bus.INTERRUPT_RAISE, 1'b1);
    ack_pulse();
    steps(2);

    // Reset landing mid-debounce of bit 1.
    raw = 8'h8E;
    steps(2);
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    steps(5);
    check("midrst_not_before", bus.SWITCHES_CLEAN, 8'h00);
    step();
    check("midrst_clean", bus.SWITCHES_CLEAN, 8'h8E);
    ack_pulse();

    // Random stimulus: per-bit flips, random acks, rare resets.
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      ack   = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 4) == 0) raw[b] = ~raw[b];
      end
      step();
    end
    rst_n = 1'b1;
    ack   = 1'b0;
    steps(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
